// File: rtl/ttt_pkg.sv
// Shared tic-tac-toe definitions: tile encoding, sequencer FSM states and the
// board-switch to tile-index wiring map.
package ttt_pkg;

  localparam int         NUM_TILES  = 9;
  localparam logic [1:0] TILE_EMPTY = 2'b00;
  localparam logic [1:0] TILE_X     = 2'b01;
  localparam logic [1:0] TILE_O     = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DEBOUNCE,
    ST_COMMIT,
    ST_SETTLE,
    ST_DONE
  } seq_state_e;

  // Board wiring: result bit n is the switch that selects tile n.
  function automatic logic [8:0] sw_to_tile(input logic [8:0] sw);
    return {sw[6], sw[7], sw[8], sw[3], sw[4], sw[5], sw[0], sw[1], sw[2]};
  endfunction

endpackage

// File: rtl/switch_conditioner.sv
// Two-flop synchroniser plus rising-edge detect for the raw board switches.
// Everything resets high so a switch held at reset must toggle before it counts.
module switch_conditioner #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] sw_in,
  output logic [W-1:0] sw_level,
  output logic [W-1:0] sw_rise
);

  logic [W-1:0] meta_q, sync_q, prev_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q <= '1;
      sync_q <= '1;
      prev_q <= '1;
    end else begin
      meta_q <= sw_in;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign sw_level = sync_q;
  assign sw_rise  = sync_q & ~prev_q;

endmodule

// File: rtl/move_sequencer.sv
// Turn/move controller: debounces and validates switch presses, issues one
// one-hot move pulse per accepted press, and owns turn, move count and timeout.
module move_sequencer
  import ttt_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int TURN_TIMEOUT    = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [8:0]  input_switches,
  input  logic [17:0] tiles,
  input  logic        game_over,
  output logic [8:0]  player_move,
  output logic        current_turn,
  output logic [3:0]  move_count,
  output logic        draw,
  output logic        timeout_pulse,
  output logic        busy
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TW = (TURN_TIMEOUT > 0) ? $clog2(TURN_TIMEOUT + 1) : 1;

  logic [8:0] sw_level, sw_rise, tile_level, tile_rise, tile_empty;
  logic       cand_vld;
  logic [3:0] cand_idx;

  seq_state_e state_q, state_d;
  logic [3:0]    idx_q, idx_d;
  logic [DW-1:0] deb_q, deb_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic          turn_q, turn_d;
  logic [3:0]    count_q, count_d;
  logic          draw_q, draw_d;
  logic [8:0]    move_q, move_d;
  logic          tpulse_q, tpulse_d;

  switch_conditioner #(.W(9)) u_cond (
    .clk      (clk),
    .reset    (reset),
    .sw_in    (input_switches),
    .sw_level (sw_level),
    .sw_rise  (sw_rise)
  );

  assign tile_level = sw_to_tile(sw_level);
  assign tile_rise  = sw_to_tile(sw_rise);

  // Highest-index empty tile with a fresh edge wins; the rest are dropped.
  always_comb begin
    tile_empty = '0;
    cand_vld   = 1'b0;
    cand_idx   = '0;
    for (int i = 0; i < 9; i++) begin
      tile_empty[i] = (tiles[2*i +: 2] == TILE_EMPTY);
      if (tile_rise[i] && tile_empty[i]) begin
        cand_vld = 1'b1;
        cand_idx = 4'(i);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    deb_d    = deb_q;
    tmr_d    = tmr_q;
    turn_d   = turn_q;
    count_d  = count_q;
    draw_d   = draw_q;
    move_d   = '0;
    tpulse_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (game_over) begin
          state_d = ST_DONE;
        end else if (cand_vld) begin
          state_d = ST_DEBOUNCE;
          idx_d   = cand_idx;
          deb_d   = '0;
        end else if (TURN_TIMEOUT > 0) begin
          if (tmr_q == TW'(TURN_TIMEOUT - 1)) begin
            turn_d   = ~turn_q;
            tpulse_d = 1'b1;
            tmr_d    = '0;
          end else begin
            tmr_d = tmr_q + TW'(1);
          end
        end
      end
      ST_DEBOUNCE: begin
        if (game_over) begin
          state_d = ST_DONE;
        end else if (!tile_level[idx_q] || !tile_empty[idx_q]) begin
          state_d = ST_IDLE;
        end else begin
          if (deb_q != DW'(DEBOUNCE_CYCLES)) deb_d = deb_q + DW'(1);
          if (deb_q == DW'(DEBOUNCE_CYCLES - 1)) state_d = ST_COMMIT;
        end
      end
      ST_COMMIT: begin
        // Output is registered, so the pulse is visible during SETTLE.
        move_d[idx_q] = 1'b1;
        state_d       = ST_SETTLE;
      end
      ST_SETTLE: begin
        turn_d = ~turn_q;
        tmr_d  = '0;
        if (count_q != 4'd9) count_d = count_q + 4'd1;
        state_d = (game_over || count_d == 4'd9) ? ST_DONE : ST_IDLE;
      end
      ST_DONE: begin
        if (count_q == 4'd9 && !game_over) draw_d = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      deb_q    <= '0;
      tmr_q    <= '0;
      turn_q   <= 1'b0;
      count_q  <= '0;
      draw_q   <= 1'b0;
      move_q   <= '0;
      tpulse_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      deb_q    <= deb_d;
      tmr_q    <= tmr_d;
      turn_q   <= turn_d;
      count_q  <= count_d;
      draw_q   <= draw_d;
      move_q   <= move_d;
      tpulse_q <= tpulse_d;
    end
  end

  assign player_move   = move_q;
  assign current_turn  = turn_q;
  assign move_count    = count_q;
  assign draw          = draw_q;
  assign timeout_pulse = tpulse_q;
  assign busy          = (state_q == ST_DEBOUNCE) || (state_q == ST_COMMIT) ||
                         (state_q == ST_SETTLE);

endmodule

// File: tb/tb_move_sequencer.sv
// Directed bench for move_sequencer: one instance without timeout, one with
// TURN_TIMEOUT=100, sharing switches/tiles/game_over but with separate resets.
module tb_move_sequencer;
  import ttt_pkg::*;

  logic        clk = 1'b0;
  logic        rst, rst2, game_over;
  logic [8:0]  sw;
  logic [17:0] tiles;
  logic [8:0]  pm, pm2;
  logic        turn, turn2, to, to2, drw, drw2, bsy, bsy2;
  logic [3:0]  cnt, cnt2;

  always #5 clk = ~clk;

  move_sequencer #(.DEBOUNCE_CYCLES(16), .TURN_TIMEOUT(0)) dut (
    .clk(clk), .reset(rst), .input_switches(sw), .tiles(tiles), .game_over(game_over),
    .player_move(pm), .current_turn(turn), .move_count(cnt), .draw(drw),
    .timeout_pulse(to), .busy(bsy)
  );

  move_sequencer #(.DEBOUNCE_CYCLES(16), .TURN_TIMEOUT(100)) dut_t (
    .clk(clk), .reset(rst2), .input_switches(sw), .tiles(tiles), .game_over(game_over),
    .player_move(pm2), .current_turn(turn2), .move_count(cnt2), .draw(drw2),
    .timeout_pulse(to2), .busy(bsy2)
  );

  int         n_tests = 0, n_fail = 0;
  int         npulse, first_at, cyc, tot;
  logic [8:0] pm_acc, tot_pm;
  int         sw2t [9] = '{2, 1, 0, 5, 4, 3, 8, 7, 6};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    npulse = 0; first_at = -1; cyc = 0; pm_acc = '0;
  endtask

  // Advance n cycles, sampling the untimed instance's move pulse at each negedge.
  task automatic run(input int n);
    repeat (n) begin
      @(negedge clk);
      cyc++;
      if (pm != 9'h000) begin
        npulse++;
        pm_acc |= pm;
        if (first_at < 0) first_at = cyc;
      end
    end
  endtask

  task automatic press(input int s, input int hold);
    clr();
    sw[s] = 1'b1;
    run(hold);
    sw[s] = 1'b0;
    run(4);
  endtask

  task automatic place(input int t, input logic who);
    tiles[2*t +: 2] = who ? TILE_O : TILE_X;
  endtask

  initial begin
    int n_to, first_to, n_p2;
    logic turn_at;
    rst = 1'b1; rst2 = 1'b1; sw = '0; tiles = '0; game_over = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_pm", pm, 9'h000);
    chk("rst_turn", turn, 0);
    chk("rst_cnt", cnt, 0);
    chk("rst_draw", drw, 0);
    chk("rst_to", to, 0);
    chk("rst_busy", bsy, 0);
    run(3);

    // 1: clean press of sw2 -> tile 0, latency 16+4
    clr();
    sw[2] = 1'b1;
    run(8);
    chk("t1_busy", bsy, 1);
    run(12);
    sw[2] = 1'b0;
    run(4);
    chk("t1_npulse", npulse, 1);
    chk("t1_pm", pm_acc, 9'h001);
    chk("t1_lat", first_at, 20);
    chk("t1_turn", turn, 1);
    chk("t1_cnt", cnt, 1);
    place(0, 1'b0);

    // 2: bouncy sw4 -> single pulse after the final high
    clr();
    sw[4] = 1'b1; run(5);
    sw[4] = 1'b0; run(3);
    sw[4] = 1'b1; run(20);
    sw[4] = 1'b0; run(4);
    chk("t2_npulse", npulse, 1);
    chk("t2_pm", pm_acc, 9'h010);
    chk("t2_lat", first_at, 28);
    chk("t2_turn", turn, 0);
    chk("t2_cnt", cnt, 2);

    // 3: occupied tile 4 -> press ignored
    tiles[9:8] = TILE_X;
    press(4, 20);
    chk("t3_npulse", npulse, 0);
    chk("t3_turn", turn, 0);
    chk("t3_cnt", cnt, 2);
    chk("t3_busy", bsy, 0);

    // 4: sw6 and sw0 together -> tile 8 only; sw0 re-toggled scores tile 2
    clr();
    sw[6] = 1'b1; sw[0] = 1'b1;
    run(20);
    sw[6] = 1'b0; sw[0] = 1'b0;
    run(4);
    chk("t4_npulse", npulse, 1);
    chk("t4_pm", pm_acc, 9'h100);
    chk("t4_cnt", cnt, 3);
    place(8, 1'b0);
    press(0, 20);
    chk("t4b_npulse", npulse, 1);
    chk("t4b_pm", pm_acc, 9'h004);
    chk("t4b_cnt", cnt, 4);
    chk("t4b_turn", turn, 0);
    place(2, 1'b1);

    // game_over mid-debounce abandons the press and locks out
    clr();
    sw[1] = 1'b1;
    run(10);
    chk("go_busy_pre", bsy, 1);
    game_over = 1'b1;
    run(2);
    chk("go_busy", bsy, 0);
    run(10);
    sw[1] = 1'b0;
    game_over = 1'b0;
    run(4);
    chk("go_npulse", npulse, 0);
    press(5, 20);
    chk("go_locked", npulse, 0);
    chk("go_cnt", cnt, 4);
    chk("go_draw", drw, 0);

    // 5: nine moves -> DONE with draw, further presses ignored
    rst = 1'b1; tiles = '0; sw = '0;
    run(2);
    rst = 1'b0;
    run(2);
    tot = 0; tot_pm = '0;
    for (int s = 0; s < 9; s++) begin
      press(s, 20);
      tot += npulse;
      tot_pm |= pm_acc;
      place(sw2t[s], (s % 2) == 1);
    end
    chk("t5_tot", tot, 9);
    chk("t5_pm", tot_pm, 9'h1FF);
    chk("t5_cnt", cnt, 9);
    chk("t5_turn", turn, 1);
    chk("t5_draw", drw, 1);
    chk("t5_busy", bsy, 0);
    tiles = '0;
    press(4, 20);
    chk("t5_locked", npulse, 0);
    chk("t5_cnt2", cnt, 9);

    // 6: timeout instance, forfeit after 100 idle cycles
    sw = '0; tiles = '0;
    rst2 = 1'b1;
    run(2);
    rst2 = 1'b0;
    n_to = 0; first_to = -1; turn_at = 1'b0;
    for (int n = 1; n <= 101; n++) begin
      @(negedge clk);
      if (to2) begin
        n_to++;
        if (first_to < 0) begin
          first_to = n;
          turn_at  = turn2;
        end
      end
    end
    chk("t6_first", first_to, 100);
    chk("t6_nto", n_to, 1);
    chk("t6_turn", turn_at, 1);
    chk("t6_cnt", cnt2, 0);

    // reset while debouncing -> reset values, held switch never scores
    sw[3] = 1'b1;
    run(6);
    chk("t6_busy", bsy2, 1);
    rst2 = 1'b1;
    #1;
    chk("t6r_pm", pm2, 9'h000);
    chk("t6r_turn", turn2, 0);
    chk("t6r_cnt", cnt2, 0);
    chk("t6r_draw", drw2, 0);
    chk("t6r_to", to2, 0);
    chk("t6r_busy", bsy2, 0);
    @(negedge clk);
    rst2 = 1'b0;
    n_p2 = 0;
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      if (pm2 != 9'h000) n_p2++;
    end
    chk("t6r_nopulse", n_p2, 0);
    chk("t6r_idle", bsy2, 0);
    sw[3] = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
